// File: rtl/fighter_pkg.sv
// -----------------------------------------------------------------------------
// fighter_pkg
// Shared types for the fighter animation path: attack codes, sprite ids and
// the sequencer state encoding, plus the state-to-sprite lookup used when the
// sprite register is refreshed at the start of vertical blank.
// -----------------------------------------------------------------------------
package fighter_pkg;

   typedef enum logic [1:0] {
      MV_NONE  = 2'd0,
      MV_PUNCH = 2'd1,
      MV_KICK  = 2'd2
   } move_t;

   typedef enum logic [2:0] {
      SPR_IDLE         = 3'd0,
      SPR_CROUCH       = 3'd1,
      SPR_PUNCH        = 3'd2,
      SPR_CROUCH_PUNCH = 3'd3,
      SPR_KICK         = 3'd4,
      SPR_HIT          = 3'd5
   } sprite_id_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WINDUP  = 3'd1,
      ACTIVE  = 3'd2,
      RECOVER = 3'd3,
      HITSTUN = 3'd4
   } anim_state_t;

   // Sprite shown for a given state. IDLE follows the live crouch button;
   // the attack phases use the crouch level captured when the attack began.
   function automatic sprite_id_t sprite_for(
      input anim_state_t st,
      input move_t       mv,
      input logic        crouch_latched,
      input logic        crouch_now
   );
      sprite_id_t spr;
      spr = SPR_IDLE;
      case (st)
         IDLE:    spr = crouch_now ? SPR_CROUCH : SPR_IDLE;
         WINDUP,
         ACTIVE: begin
            if (mv == MV_KICK)
               spr = SPR_KICK;
            else if (mv == MV_PUNCH)
               spr = crouch_latched ? SPR_CROUCH_PUNCH : SPR_PUNCH;
            else
               spr = crouch_latched ? SPR_CROUCH : SPR_IDLE;
         end
         RECOVER: spr = crouch_latched ? SPR_CROUCH : SPR_IDLE;
         HITSTUN: spr = SPR_HIT;
         default: spr = SPR_IDLE;
      endcase
      return spr;
   endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// -----------------------------------------------------------------------------
// anim_frame_counter
// Loadable 4-bit down-counter measuring phase length in video frames.
//   vga_clk   : pixel clock
//   reset_n   : asynchronous active-low reset (count -> 0)
//   load      : load load_val this cycle (wins over a decrement)
//   load_val  : phase length, 1..15
//   dec_en    : decrement enable, driven by frame_start
//   last      : count == 1, i.e. the next decrement ends the phase
// The count holds at zero so an idle sequencer never wraps to 15.
// -----------------------------------------------------------------------------
module anim_frame_counter (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec_en,
   output logic       last
);

   logic [3:0] count;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n)
         count <= 4'd0;
      else if (load)
         count <= load_val;
      else if (dec_en && count != 4'd0)
         count <= count - 4'd1;
   end

   assign last = (count == 4'd1);

endmodule

// File: rtl/fighter_anim_sequencer.sv
// -----------------------------------------------------------------------------
// fighter_anim_sequencer
// Sequences a fighter's attack animation: IDLE -> WINDUP -> ACTIVE -> RECOVER
// -> IDLE, with a HITSTUN detour whenever the fighter is struck. Phase lengths
// are counted in video frames (frame_start pulses).
//   vga_clk     : pixel clock
//   reset_n     : asynchronous active-low reset
//   frame_start : one-cycle pulse at the start of vertical blank
//   move_valid  : attack request valid
//   move_req    : attack code (move_t)
//   crouch_hold : crouch button level
//   hit_taken   : one-cycle pulse when the fighter is struck
//   move_ack    : one-cycle pulse when an attack is accepted
//   busy        : high in any state other than IDLE
//   hit_active  : high in ACTIVE only (hitbox live)
//   sprite_sel  : sprite_id_t, refreshed only at frame_start
// -----------------------------------------------------------------------------
module fighter_anim_sequencer
   import fighter_pkg::*;
#(
   parameter int WINDUP_FRAMES  = 3,
   parameter int ACTIVE_FRAMES  = 4,
   parameter int RECOVER_FRAMES = 6,
   parameter int HITSTUN_FRAMES = 10
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_start,
   input  logic       move_valid,
   input  logic [1:0] move_req,
   input  logic       crouch_hold,
   input  logic       hit_taken,
   output logic       move_ack,
   output logic       busy,
   output logic       hit_active,
   output logic [2:0] sprite_sel
);

   localparam logic [3:0] WINDUP_LEN  = WINDUP_FRAMES[3:0];
   localparam logic [3:0] ACTIVE_LEN  = ACTIVE_FRAMES[3:0];
   localparam logic [3:0] RECOVER_LEN = RECOVER_FRAMES[3:0];
   localparam logic [3:0] HITSTUN_LEN = HITSTUN_FRAMES[3:0];

   anim_state_t state, state_nxt;
   move_t       move_lat;
   logic        crouch_lat;
   sprite_id_t  sprite_q;

   logic        cnt_load;
   logic [3:0]  cnt_load_val;
   logic        cnt_last;
   logic        accept;

   anim_frame_counter u_frame_cnt (
      .vga_clk  (vga_clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec_en   (frame_start),
      .last     (cnt_last)
   );

   // Next-state decision. A hit outranks both a new request and a
   // phase-ending frame; a hit during HITSTUN does not restart the stun.
   // Phases end on the frame_start where the counter reads 1, so a phase of
   // N frames spans exactly N pulses.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned and infers a latch.
      state_nxt    = state;
      cnt_load     = 1'b0;
      cnt_load_val = 4'd0;
      accept       = 1'b0;

      if (hit_taken && state != HITSTUN) begin
         state_nxt    = HITSTUN;
         cnt_load     = 1'b1;
         cnt_load_val = HITSTUN_LEN;
      end else begin
         case (state)
            IDLE: begin
               if (move_valid && move_t'(move_req) != MV_NONE) begin
                  state_nxt    = WINDUP;
                  cnt_load     = 1'b1;
                  cnt_load_val = WINDUP_LEN;
                  accept       = 1'b1;
               end
            end
            WINDUP: begin
               if (frame_start && cnt_last) begin
                  state_nxt    = ACTIVE;
                  cnt_load     = 1'b1;
                  cnt_load_val = ACTIVE_LEN;
               end
            end
            ACTIVE: begin
               if (frame_start && cnt_last) begin
                  state_nxt    = RECOVER;
                  cnt_load     = 1'b1;
                  cnt_load_val = RECOVER_LEN;
               end
            end
            RECOVER,
            HITSTUN: begin
               // The closing decrement takes the counter to zero on its own.
               if (frame_start && cnt_last)
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // busy/hit_active are derived from state_nxt so they change on the same
   // edge as the state register. The sprite samples the pre-edge state so a
   // change only ever lands at the start of vertical blank.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         move_lat   <= MV_NONE;
         crouch_lat <= 1'b0;
         move_ack   <= 1'b0;
         busy       <= 1'b0;
         hit_active <= 1'b0;
         sprite_q   <= SPR_IDLE;
      end else begin
         state      <= state_nxt;
         move_ack   <= accept;
         busy       <= (state_nxt != IDLE);
         hit_active <= (state_nxt == ACTIVE);
         if (accept) begin
            move_lat   <= move_t'(move_req);
            crouch_lat <= crouch_hold;
         end
         if (frame_start)
            sprite_q <= sprite_for(state, move_lat, crouch_lat, crouch_hold);
      end
   end

   assign sprite_sel = sprite_q;

endmodule

// File: tb/tb_fighter_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fighter_anim_sequencer
// Scoreboard bench. A reference model of the attack timeline (frames elapsed
// since the attack began, frames of stun remaining) steps on every clock edge
// and queues the outputs it expects; a monitor pops and compares them on the
// falling edge. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_fighter_anim_sequencer;

   localparam int W  = 3;
   localparam int A  = 4;
   localparam int R  = 6;
   localparam int HS = 10;

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       move_valid = 1'b0;
   logic [1:0] move_req = 2'd0;
   logic       crouch_hold = 1'b0;
   logic       hit_taken = 1'b0;
   logic       move_ack;
   logic       busy;
   logic       hit_active;
   logic [2:0] sprite_sel;

   int n_cmp  = 0;
   int n_fail = 0;

   fighter_anim_sequencer #(
      .WINDUP_FRAMES  (W),
      .ACTIVE_FRAMES  (A),
      .RECOVER_FRAMES (R),
      .HITSTUN_FRAMES (HS)
   ) dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .move_valid  (move_valid),
      .move_req    (move_req),
      .crouch_hold (crouch_hold),
      .hit_taken   (hit_taken),
      .move_ack    (move_ack),
      .busy        (busy),
      .hit_active  (hit_active),
      .sprite_sel  (sprite_sel)
   );

   always #5 vga_clk = ~vga_clk;

   // Packed as {ack, busy, hit_active, sprite[2:0]}.
   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got ack=%b busy=%b hit=%b spr=%0d, want ack=%b busy=%b hit=%b spr=%0d",
                  name, $time, act[5], act[4], act[3], act[2:0], exp[5], exp[4], exp[3], exp[2:0]);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 = idle, 1 = attacking, 2 = stunned
   int   m_mode = 0;
   int   m_pulses = 0;     // frame_start pulses since the attack was accepted
   int   m_stun_left = 0;  // stun frames still to run
   int   m_move = 0;
   bit   m_crouch = 0;
   bit   m_ack = 0;
   logic [2:0] m_spr = 3'd0;
   logic [5:0] exp_q[$];

   function automatic logic [2:0] model_sprite(input bit ch_now);
      if (m_mode == 0) return ch_now ? 3'd1 : 3'd0;
      if (m_mode == 2) return 3'd5;
      if (m_pulses < W + A) begin
         if (m_move == 2) return 3'd4;
         return m_crouch ? 3'd3 : 3'd2;
      end
      return m_crouch ? 3'd1 : 3'd0;
   endfunction

   initial begin
      forever begin
         @(posedge vga_clk);
         if (!reset_n) begin
            m_mode = 0; m_pulses = 0; m_stun_left = 0; m_move = 0;
            m_crouch = 0; m_ack = 0; m_spr = 3'd0;
         end else begin
            m_ack = 0;
            if (frame_start) m_spr = model_sprite(crouch_hold);
            if (hit_taken && m_mode != 2) begin
               m_mode = 2;
               m_stun_left = HS;
            end else if (m_mode == 0 && move_valid && move_req != 2'd0) begin
               m_mode = 1; m_pulses = 0; m_move = move_req;
               m_crouch = crouch_hold; m_ack = 1;
            end else if (frame_start && m_mode == 1) begin
               m_pulses++;
               if (m_pulses == W + A + R) m_mode = 0;
            end else if (frame_start && m_mode == 2) begin
               m_stun_left--;
               if (m_stun_left == 0) m_mode = 0;
            end
         end
         exp_q.push_back({m_ack, (m_mode != 0),
                          (m_mode == 1 && m_pulses >= W && m_pulses < W + A), m_spr});
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic [5:0] e;
      forever begin
         @(negedge vga_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {move_ack, busy, hit_active, sprite_sel}, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit fs, input bit mv, input logic [1:0] mr,
                      input bit ch, input bit ht);
      @(negedge vga_clk);
      frame_start = fs; move_valid = mv; move_req = mr;
      crouch_hold = ch; hit_taken = ht;
   endtask

   task automatic frames(input int n, input bit mv, input logic [1:0] mr, input bit ch);
      repeat (n) begin
         cyc(1, mv, mr, ch, 0);
         repeat (3) cyc(0, mv, mr, ch, 0);
      end
   endtask

   task automatic do_reset(input bit check_now);
      @(negedge vga_clk);
      #2 reset_n = 1'b0;
      frame_start = 0; move_valid = 0; move_req = 0; crouch_hold = 0; hit_taken = 0;
      #1 if (check_now) check("rst_async", {move_ack, busy, hit_active, sprite_sel}, 6'd0);
      repeat (2) @(negedge vga_clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge vga_clk);
      #2 reset_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);  // idle sprite update
      cyc(1, 0, 0, 1, 0);  // idle crouch sprite
      cyc(0, 0, 0, 0, 0);

      // default punch: 13 frames end to end
      cyc(0, 1, 2'd1, 0, 0);
      frames(14, 0, 0, 0);

      // crouch punch
      cyc(0, 1, 2'd1, 1, 0);
      frames(14, 0, 0, 1);

      // kick, struck in the second active frame, then a hit ignored mid-stun
      cyc(0, 1, 2'd2, 0, 0);
      frames(W + 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      frames(3, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      frames(8, 0, 0, 0);

      // hit and request in the same idle cycle
      cyc(0, 1, 2'd2, 0, 1);
      frames(11, 0, 0, 0);

      // request held through the whole attack, re-accepted once idle
      cyc(0, 1, 2'd1, 0, 0);
      frames(14, 1, 2'd1, 0);
      cyc(0, 0, 0, 0, 0);
      frames(14, 0, 0, 0);

      // hit coinciding with a phase-ending frame_start
      cyc(0, 1, 2'd1, 0, 0);
      frames(W - 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 1);
      frames(11, 0, 0, 0);

      // reset during windup
      cyc(0, 1, 2'd1, 0, 0);
      frames(1, 0, 0, 0);
      do_reset(1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 699) == 0)
            do_reset(1);
         else
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0));
      end

      cyc(0, 0, 0, 0, 0);
      repeat (2) @(negedge vga_clk);
      #1;
      if (n_cmp < 12) begin
         n_fail++;
         $display("FAIL too_few_compares: got %0d, want >= 12", n_cmp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fighter_anim_sequencer.md
FIGHTER_ANIM_SEQUENCER -- requirements
Module: fighter_anim_sequencer

Interface
REQ-001 SHALL provide parameter WINDUP_FRAMES, default 3, windup phase length in video frames (1..15).
REQ-002 SHALL provide parameter ACTIVE_FRAMES, default 4, active (hitbox-live) phase length in video frames (1..15).
REQ-003 SHALL provide parameter RECOVER_FRAMES, default 6, recovery phase length in video frames (1..15).
REQ-004 SHALL provide parameter HITSTUN_FRAMES, default 10, hit-stun length in video frames (1..15).
REQ-005 SHALL have port vga_clk, input, 1, the single clock, pixel clock domain.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port frame_start, input, 1, one-cycle pulse at the start of vertical blank.
REQ-008 SHALL have port move_valid, input, 1, attack request valid.
REQ-009 SHALL have port move_req, input, 2, attack code (move_t).
REQ-010 SHALL have port crouch_hold, input, 1, crouch button level.
REQ-011 SHALL have port hit_taken, input, 1, one-cycle pulse when the fighter is struck.
REQ-012 SHALL have port move_ack, output, 1, one-cycle pulse when an attack is accepted.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port hit_active, output, 1, high in ACTIVE only, to the collision logic.
REQ-015 SHALL have port sprite_sel, output, 3, sprite_id_t, selects the sprite ROM/palette pair feeding the pixel mux.

Function
REQ-016 SHALL implement states IDLE, WINDUP, ACTIVE, RECOVER, HITSTUN.
REQ-017 SHALL accept an attack only in IDLE with move_valid=1 and move_req != MV_NONE: next cycle move_ack=1 for exactly one cycle, state=WINDUP, and the attack code and crouch_hold are latched.
REQ-018 SHALL ignore move_valid in every state except IDLE, with no ack and no queuing.
REQ-019 SHALL load a 4-bit frame counter with the phase length on phase entry and decrement it only on frame_start cycles.
REQ-020 SHALL transition WINDUP->ACTIVE->RECOVER->IDLE, and HITSTUN->IDLE, on the frame_start where the counter equals 1, so that each phase spans exactly N frame_start pulses.
REQ-021 SHALL enter HITSTUN on the cycle after hit_taken from IDLE, WINDUP, ACTIVE or RECOVER, and SHALL ignore hit_taken while already in HITSTUN, with no restart.
REQ-022 SHALL give hit_taken priority when it coincides with move_valid in IDLE: enter HITSTUN and assert no move_ack.
REQ-023 SHALL give hit_taken priority when it coincides with a phase-ending frame_start.
REQ-024 SHALL update sprite_sel only on frame_start cycles, registered one cycle after the pulse, from the state current at the pulse, so that no sprite changes mid-frame.
REQ-025 SHALL map sprite_sel as follows: IDLE gives SPR_CROUCH if crouch_hold else SPR_IDLE; WINDUP/ACTIVE with MV_PUNCH gives SPR_CROUCH_PUNCH if crouch was latched else SPR_PUNCH; WINDUP/ACTIVE with MV_KICK gives SPR_KICK; RECOVER gives SPR_CROUCH if crouch was latched else SPR_IDLE; HITSTUN gives SPR_HIT.
REQ-026 SHALL register busy and hit_active so that they follow the state with zero additional delay beyond the state register.

Reset
REQ-027 SHALL, while reset_n=0, force state=IDLE, counter=0, latched move=MV_NONE, move_ack=0, busy=0, hit_active=0 and sprite_sel=SPR_IDLE, asynchronously.
REQ-028 SHALL, on reset assertion mid-attack, abandon the sequence immediately, and after release SHALL treat the first frame_start as an IDLE update.

Structure
REQ-029 SHALL place move_t (MV_NONE=0, MV_PUNCH=1, MV_KICK=2) and sprite_id_t (SPR_IDLE=0, SPR_CROUCH=1, SPR_PUNCH=2, SPR_CROUCH_PUNCH=3, SPR_KICK=4, SPR_HIT=5) in the shared package fighter_pkg.
REQ-030 SHALL contain one sub-module, anim_frame_counter, a loadable 4-bit down-counter with a decrement enable on frame_start and a last-frame flag.

Verification
REQ-031 SHALL cover the default punch: move_valid=1, MV_PUNCH in IDLE -> move_ack 1 cycle, sprite_sel=SPR_PUNCH after the next frame_start, hit_active high for exactly 4 frames, IDLE after 13 frame_start pulses.
REQ-032 SHALL cover the crouch punch: crouch_hold=1 with MV_PUNCH -> SPR_CROUCH_PUNCH through windup/active, then SPR_CROUCH in recovery.
REQ-033 SHALL cover hit_taken during ACTIVE frame 2 -> hit_active drops the next cycle, SPR_HIT on the next frame_start, IDLE after 10 frame_start pulses.
REQ-034 SHALL cover coincidence: hit_taken and move_valid in the same IDLE cycle -> no move_ack, HITSTUN.
REQ-035 SHALL cover a busy request: move_valid held through RECOVER -> no ack until IDLE, then ack 1 cycle after IDLE is reached.
REQ-036 SHALL cover reset: reset_n low during WINDUP -> all outputs at reset values within the same cycle, sprite_sel=SPR_IDLE.
